// File: rtl/emmc_ddr_data_tx.sv
// rtl/emmc_ddr_data_tx.sv - eMMC DDR write-data serialiser: start bit, payload, per-line CRC16, end bit
// Drives rise/fall halves for ODDR cells; every bus step is gated by the card-clock tick CE.
module emmc_ddr_data_tx #(
  parameter int BUS_W = 4,
  parameter int LEN_W = 12
) (
  input  logic               C,
  input  logic               R,
  input  logic               CE,
  input  logic               start,
  input  logic [LEN_W-1:0]   blk_len,
  input  logic [2*BUS_W-1:0] din,
  input  logic               din_valid,
  output logic               din_ready,
  output logic [BUS_W-1:0]   dat_rise,
  output logic [BUS_W-1:0]   dat_fall,
  output logic               dat_oe,
  output logic               clk_hold,
  output logic               busy,
  output logic               done,
  output logic               len_err
);

  localparam int SH = (BUS_W == 8) ? 3 : (BUS_W == 4) ? 2 : 0;
  localparam int CW = LEN_W + 2;
  // Low bits of blk_len*4 that must be zero for a whole number of beats.
  localparam logic [CW-1:0] LOW_MASK = CW'((1 << SH) - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_CRC, S_END, S_STOP} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   len_x4;
  logic [CW-1:0]   beat_cnt;
  logic [3:0]      bit_cnt;
  logic [15:0]     crc_r [BUS_W];
  logic [15:0]     crc_f [BUS_W];
  logic            len_ok;
  logic            accept;
  logic            take;

  assign len_x4    = {blk_len, 2'b00};
  assign len_ok    = (blk_len != '0) && ((len_x4 & LOW_MASK) == '0);
  assign din_ready = CE && (state == S_DATA) && !R;
  assign take      = din_ready && din_valid;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  always_ff @(posedge C) begin
    if (R) state <= S_IDLE;
    else   state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && len_ok) begin
          state_nx = S_START;
          accept   = 1'b1;
        end
      end
      S_START: if (CE) state_nx = S_DATA;
      S_DATA:  if (take && beat_cnt == CW'(1)) state_nx = S_CRC;
      S_CRC:   if (CE && bit_cnt == 4'd15) state_nx = S_END;
      S_END:   if (CE) state_nx = S_STOP;
      S_STOP:  if (CE) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge C) begin
    if (R) begin
      dat_rise <= '1;
      dat_fall <= '1;
      dat_oe   <= 1'b0;
      clk_hold <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      len_err  <= 1'b0;
      beat_cnt <= '0;
      bit_cnt  <= '0;
      for (int i = 0; i < BUS_W; i++) begin
        crc_r[i] <= '0;
        crc_f[i] <= '0;
      end
    end else begin
      done    <= 1'b0;
      len_err <= (state == S_IDLE) && start && !len_ok;
      case (state)
        S_IDLE: begin
          if (accept) begin
            busy     <= 1'b1;
            beat_cnt <= len_x4 >> SH;
            bit_cnt  <= '0;
            for (int i = 0; i < BUS_W; i++) begin
              crc_r[i] <= '0;
              crc_f[i] <= '0;
            end
          end
        end
        S_START: begin
          if (CE) begin
            dat_rise <= '0;
            dat_fall <= '0;
            dat_oe   <= 1'b1;
          end
        end
        S_DATA: begin
          // Underrun: bus value is held and the card clock must be stopped.
          if (CE) begin
            clk_hold <= !din_valid;
            if (take) begin
              dat_rise <= din[BUS_W-1:0];
              dat_fall <= din[2*BUS_W-1:BUS_W];
              beat_cnt <= beat_cnt - 1'b1;
              for (int i = 0; i < BUS_W; i++) begin
                crc_r[i] <= crc16_step(crc_r[i], din[i]);
                crc_f[i] <= crc16_step(crc_f[i], din[BUS_W+i]);
              end
            end
          end
        end
        S_CRC: begin
          if (CE) begin
            for (int i = 0; i < BUS_W; i++) begin
              dat_rise[i] <= crc_r[i][15];
              dat_fall[i] <= crc_f[i][15];
              crc_r[i]    <= {crc_r[i][14:0], 1'b0};
              crc_f[i]    <= {crc_f[i][14:0], 1'b0};
            end
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        S_END: begin
          if (CE) begin
            dat_rise <= '1;
            dat_fall <= '1;
          end
        end
        S_STOP: begin
          if (CE) begin
            dat_oe <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_emmc_ddr_data_tx.sv
// tb/tb_emmc_ddr_data_tx.sv - directed bench for emmc_ddr_data_tx at BUS_W 1, 4 and 8
module tb_emmc_ddr_data_tx;

  logic        C = 1'b0;
  logic        R, CE, start, din_valid;
  logic [11:0] blk_len;
  logic [15:0] din;
  int          sel;
  int          tests = 0;
  int          fails = 0;

  logic s1, s4, s8;
  assign s1 = start && (sel == 1);
  assign s4 = start && (sel == 4);
  assign s8 = start && (sel == 8);

  logic       u1_ready, u1_oe, u1_hold, u1_busy, u1_done, u1_err;
  logic [0:0] u1_rise, u1_fall;
  logic       u4_ready, u4_oe, u4_hold, u4_busy, u4_done, u4_err;
  logic [3:0] u4_rise, u4_fall;
  logic       u8_ready, u8_oe, u8_hold, u8_busy, u8_done, u8_err;
  logic [7:0] u8_rise, u8_fall;

  emmc_ddr_data_tx #(.BUS_W(1), .LEN_W(12)) u1 (
    .C(C), .R(R), .CE(CE), .start(s1), .blk_len(blk_len), .din(din[1:0]),
    .din_valid(din_valid), .din_ready(u1_ready), .dat_rise(u1_rise), .dat_fall(u1_fall),
    .dat_oe(u1_oe), .clk_hold(u1_hold), .busy(u1_busy), .done(u1_done), .len_err(u1_err));

  emmc_ddr_data_tx #(.BUS_W(4), .LEN_W(12)) u4 (
    .C(C), .R(R), .CE(CE), .start(s4), .blk_len(blk_len), .din(din[7:0]),
    .din_valid(din_valid), .din_ready(u4_ready), .dat_rise(u4_rise), .dat_fall(u4_fall),
    .dat_oe(u4_oe), .clk_hold(u4_hold), .busy(u4_busy), .done(u4_done), .len_err(u4_err));

  emmc_ddr_data_tx #(.BUS_W(8), .LEN_W(12)) u8 (
    .C(C), .R(R), .CE(CE), .start(s8), .blk_len(blk_len), .din(din[15:0]),
    .din_valid(din_valid), .din_ready(u8_ready), .dat_rise(u8_rise), .dat_fall(u8_fall),
    .dat_oe(u8_oe), .clk_hold(u8_hold), .busy(u8_busy), .done(u8_done), .len_err(u8_err));

  always #5 C = ~C;

  logic [7:0] o_rise, o_fall;
  logic       o_ready, o_oe, o_hold, o_busy, o_done, o_err;

  always_comb begin
    o_rise = {7'b0, u1_rise}; o_fall = {7'b0, u1_fall};
    o_ready = u1_ready; o_oe = u1_oe; o_hold = u1_hold;
    o_busy = u1_busy; o_done = u1_done; o_err = u1_err;
    if (sel == 4) begin
      o_rise = {4'b0, u4_rise}; o_fall = {4'b0, u4_fall};
      o_ready = u4_ready; o_oe = u4_oe; o_hold = u4_hold;
      o_busy = u4_busy; o_done = u4_done; o_err = u4_err;
    end else if (sel == 8) begin
      o_rise = u8_rise; o_fall = u8_fall;
      o_ready = u8_ready; o_oe = u8_oe; o_hold = u8_hold;
      o_busy = u8_busy; o_done = u8_done; o_err = u8_err;
    end
  end

  typedef struct {
    int   w;
    int   blen;
    logic exp_err;
    logic exp_busy;
  } len_vec_t;

  len_vec_t   vec[6];
  logic [7:0]  obs_r[$];
  logic [7:0]  obs_f[$];
  logic [15:0] data_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    c = c << 1;
    if (fb) c = c ^ 16'h1021;
    return c;
  endfunction

  function automatic logic [7:0] lane_mask(input int w);
    return 8'((1 << w) - 1);
  endfunction

  // One block on instance w; data pattern: 0 zeros, 1 single rise bit on line 0, 2 pseudo-random.
  task automatic xfer(input int w, input int blen, input int ce_per, input int stall_beat,
                      input int stall_n, input bit restart_mid, input int pat);
    int          nbeat, bi, stall_left, hold_cnt, held_bad, frz_bad, done_cnt, cyc, post;
    int          pay_bad, crc_bad, budget, last;
    logic [7:0]  mask, pr, pf;
    logic        poe, pbusy, ce_q;
    logic [15:0] d;
    logic [15:0] er[8];
    logic [15:0] ef[8];
    nbeat = blen * 4 / w;
    mask  = lane_mask(w);
    data_q.delete(); obs_r.delete(); obs_f.delete();
    for (int j = 0; j < nbeat; j++) begin
      case (pat)
        0:       d = 16'h0000;
        1:       d = (j == 0) ? 16'h0001 : 16'h0000;
        default: d = 16'(j * 16'h3B1) ^ 16'h5A3C;
      endcase
      data_q.push_back(d);
    end
    for (int i = 0; i < 8; i++) begin er[i] = '0; ef[i] = '0; end
    for (int j = 0; j < nbeat; j++)
      for (int i = 0; i < w; i++) begin
        er[i] = crc_step(er[i], data_q[j][i]);
        ef[i] = crc_step(ef[i], data_q[j][w+i]);
      end

    sel = w; blk_len = 12'(blen); din_valid = 0; din = '0; CE = 0; start = 1;
    @(posedge C); #1;
    start = 0;
    check("accept_busy", o_busy, 1);
    bi = 0; stall_left = stall_n; hold_cnt = 0; held_bad = 0; frz_bad = 0;
    done_cnt = 0; cyc = 0; post = -1;
    budget = (nbeat + 30 + stall_n) * ce_per + 20;
    while (cyc < budget && post != 0) begin
      CE        = (cyc % ce_per) == 0;
      din_valid = (bi < nbeat) && !(bi == stall_beat && stall_left > 0);
      din       = (bi < nbeat) ? data_q[bi] : 16'h0;
      start     = restart_mid && (bi == 10);
      pr = o_rise; pf = o_fall; poe = o_oe; pbusy = o_busy; ce_q = CE;
      #1;
      if (CE && o_ready) begin
        if (din_valid) bi++;
        else stall_left--;
      end
      @(posedge C); #1;
      if (ce_q) begin
        if (o_hold) begin
          hold_cnt++;
          if (o_rise !== pr || o_fall !== pf) held_bad++;
        end else if (o_oe) begin
          obs_r.push_back(o_rise);
          obs_f.push_back(o_fall);
        end
      end else if (o_rise !== pr || o_fall !== pf || o_oe !== poe || o_busy !== pbusy) begin
        frz_bad++;
      end
      if (o_done) begin
        done_cnt++;
        if (post < 0) post = 4;
      end
      if (post > 0) post--;
      cyc++;
    end
    start = 0; CE = 0; din_valid = 0;

    check("xfer_complete", post == 0, 1);
    check("done_once", done_cnt, 1);
    check("beats_taken", bi, nbeat);
    check("oe_span", obs_r.size(), nbeat + 18);
    check("clk_hold_cycles", hold_cnt, stall_n);
    check("held_outputs", held_bad, 0);
    check("ce_freeze", frz_bad, 0);
    check("idle_oe", o_oe, 0);
    check("idle_busy", o_busy, 0);
    check("idle_rise", o_rise, mask);
    if (obs_r.size() == nbeat + 18) begin
      check("start_bit", {obs_r[0], obs_f[0]}, 16'h0000);
      pay_bad = 0;
      for (int j = 0; j < nbeat; j++) begin
        if (obs_r[1+j] !== (8'(data_q[j]) & mask)) pay_bad++;
        if (obs_f[1+j] !== (8'(data_q[j] >> w) & mask)) pay_bad++;
      end
      check("payload", pay_bad, 0);
      crc_bad = 0;
      for (int k = 0; k < 16; k++)
        for (int i = 0; i < w; i++) begin
          if (obs_r[1+nbeat+k][i] !== er[i][15-k]) crc_bad++;
          if (obs_f[1+nbeat+k][i] !== ef[i][15-k]) crc_bad++;
        end
      check("crc_bits", crc_bad, 0);
      last = nbeat + 17;
      check("end_bit", {obs_r[last], obs_f[last]}, {mask, mask});
    end
  endtask

  initial begin
    logic [15:0] cr, cf, acc;
    int          dcnt;
    R = 1; CE = 1; start = 0; din_valid = 0; din = '0; blk_len = '0; sel = 4;
    repeat (3) @(posedge C);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = (s == 0) ? 1 : (s == 1) ? 4 : 8;
      #1;
      check("rst_rise", o_rise, lane_mask(sel));
      check("rst_fall", o_fall, lane_mask(sel));
      check("rst_ctrl", {o_oe, o_hold, o_busy, o_done, o_err, o_ready}, 6'b0);
    end
    R = 0;
    @(posedge C); #1;

    vec[0] = '{8, 3, 1'b1, 1'b0};
    vec[1] = '{8, 0, 1'b1, 1'b0};
    vec[2] = '{4, 0, 1'b1, 1'b0};
    vec[3] = '{1, 0, 1'b1, 1'b0};
    vec[4] = '{8, 2, 1'b0, 1'b1};
    vec[5] = '{4, 1, 1'b0, 1'b1};
    for (int k = 0; k < 6; k++) begin
      sel = vec[k].w; blk_len = 12'(vec[k].blen); CE = 0; start = 1;
      @(posedge C); #1;
      start = 0;
      check($sformatf("len_err[%0d]", k), o_err, vec[k].exp_err);
      check($sformatf("busy_on_start[%0d]", k), o_busy, vec[k].exp_busy);
      check($sformatf("oe_low[%0d]", k), o_oe, 0);
      @(posedge C); #1;
      check($sformatf("len_err_pulse[%0d]", k), o_err, 0);
      R = 1;
      @(posedge C); #1;
      R = 0;
    end

    xfer(1, 1, 1, -1, 0, 1'b0, 1);
    if (obs_r.size() == 22) begin
      cr = '0; cf = '0;
      for (int k = 0; k < 16; k++) begin
        cr = {cr[14:0], obs_r[5+k][0]};
        cf = {cf[14:0], obs_f[5+k][0]};
      end
      check("w1_rise_crc", cr, 16'h8108);
      check("w1_fall_crc", cf, 16'h0000);
    end

    xfer(4, 512, 2, -1, 0, 1'b0, 0);
    if (obs_r.size() == 530) begin
      acc = '0;
      for (int k = 0; k < 16; k++) acc = acc | {obs_r[513+k], obs_f[513+k]};
      check("w4_zero_crcs", acc, 16'h0000);
    end

    xfer(4, 128, 1, 100, 5, 1'b0, 2);
    xfer(4, 16, 1, -1, 0, 1'b1, 2);
    xfer(8, 2, 3, -1, 0, 1'b0, 2);
    xfer(4, 1, 1, -1, 0, 1'b0, 2);

    sel = 4; blk_len = 12'd2; CE = 1; din_valid = 1; din = 16'h00A5; start = 1;
    @(posedge C); #1;
    start = 0;
    repeat (9) @(posedge C);
    #1;
    check("in_crc_oe", o_oe, 1);
    check("in_crc_busy", o_busy, 1);
    R = 1;
    @(posedge C); #1;
    check("abort_oe", o_oe, 0);
    check("abort_rise", o_rise, 8'h0F);
    check("abort_fall", o_fall, 8'h0F);
    check("abort_busy", o_busy, 0);
    check("abort_done", o_done, 0);
    R = 0;
    dcnt = 0;
    repeat (30) begin
      @(posedge C); #1;
      if (o_done || o_oe || o_busy) dcnt++;
    end
    check("abort_quiet", dcnt, 0);
    din_valid = 0;
    xfer(4, 2, 1, -1, 0, 1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
